obi_data_mem_responder: RTL and testbench
=========================================

OBI_DATA_MEM_RESPONDER -- requirements
Module: obi_data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the memory array (power of 2, at least 4).
REQ-002 SHALL have parameter GNT_DELAY, default 0, meaning the number of cycles a request is held before it is granted (0..7).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  core data request.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port be_i  input  4  byte enables, bit k = byte lane k.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port gnt_o  output  1  request grant.
REQ-011 SHALL have port rvalid_o  output  1  response valid, one-cycle pulse.
REQ-012 SHALL have port rdata_o  output  32  read data, valid when rvalid_o is high.

Function
REQ-013 SHALL index the word as addr_i[log2(MEM_WORDS)+1:2]; upper bits ignored (wrap modulo MEM_WORDS); addr_i[1:0] ignored for indexing.
REQ-014 SHALL drive gnt_o combinationally = req_i AND stall counter == 0 AND gnt_o was low in the previous cycle, so gnt_o is never high without req_i and never high two cycles in a row.
REQ-015 SHALL load the stall counter with GNT_DELAY on the first cycle req_i is high after idle or after a grant, decrement it each cycle req_i stays high, and clear it when req_i drops before grant.
REQ-016 With GNT_DELAY=0, SHALL grant a request in the same cycle req_i rises; with GNT_DELAY=d, SHALL grant d cycles after req_i rises while req_i is held.
REQ-017 SHALL accept a transaction only in a cycle where req_i and gnt_o are both high (cycle N), capturing we_i, addr_i, be_i, wdata_i.
REQ-018 Write accepted at N: SHALL update exactly the byte lanes with be_i[k]=1 at the end of N; be_i=0000 changes nothing but still responds.
REQ-019 Write accepted at N: SHALL pulse rvalid_o at N+1 with rdata_o = 0.
REQ-020 Read accepted at N: SHALL read the full word at the end of N, hold it in a 2-stage pipeline, and pulse rvalid_o at N+2 with that word (lane extraction is the core's job).
REQ-021 A read accepted at N+2 or later to an address written at N SHALL return the new data.
REQ-022 rvalid_o SHALL be high for exactly one cycle per accepted transaction; responses are returned in acceptance order; with the grant spacing of REQ-014, read and write responses never collide, and no response SHALL be dropped.
REQ-023 rdata_o SHALL be 0 whenever rvalid_o is low.
REQ-024 The memory array SHALL be initialised to all zeros at time zero, so reads never return X.
REQ-025 Inputs sampled while req_i is low SHALL have no effect.

Reset
REQ-026 While rst_n is low: gnt_o=0, rvalid_o=0, rdata_o=0, stall counter=0, and the response pipeline is empty, applied asynchronously.
REQ-027 Reset asserted mid-transaction SHALL discard all pending responses; no rvalid_o pulse SHALL appear after reset for a transaction accepted before it.
REQ-028 Memory contents SHALL NOT be altered by reset.
REQ-029 After rst_n rises, the first grant SHALL follow REQ-016 counted from the first cycle req_i is high.

Verification
REQ-030 GNT_DELAY=0: write addr 0x10, be 1111, data 0xDEADBEEF -> gnt at N, rvalid at N+1 with rdata 0; then read 0x10 -> rvalid 2 cycles after gnt with rdata 0xDEADBEEF.
REQ-031 Write 0x11223344 to 0x20, then be 0100 data 0x00AA0000 -> read 0x22 returns 0x11AA3344.
REQ-032 req_i held high continuously for 4 reads, GNT_DELAY=0 -> gnt pulses every other cycle, four single-cycle rvalid pulses in order, never gnt for two consecutive cycles.
REQ-033 GNT_DELAY=3: req rises at cycle 0 -> gnt at cycle 3; req dropped at cycle 1 and raised at cycle 2 -> gnt at cycle 5.
REQ-034 Read accepted at N, rst_n low at N+1 -> rvalid_o stays 0 through N+3; memory data still readable after reset.
REQ-035 MEM_WORDS=1024: write to 0x1000 and read 0x0000 -> same word (wrap).

Source files
------------

// File: rtl/obi_data_mem_responder.sv
// OBI data-memory responder: byte-enabled word RAM with a programmable grant
// delay, single-cycle write responses and two-stage registered read responses.
module obi_data_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam logic [2:0]  DELAY = 3'(GNT_DELAY);

  // Zero image at configuration time; reset never touches the array.
  logic [31:0] mem_q [MEM_WORDS] = '{default: 32'h0};

  logic [AW-1:0] idx;
  logic          unused_addr;

  logic [2:0]  cnt_q, cnt_d, cnt_eff;
  logic        wait_q, wait_d;
  logic        gnt_prev_q, gnt_prev_d;
  logic        wr_acc, rd_acc;
  logic        wr_rsp_q, wr_rsp_d;
  logic        rd1_vld_q, rd1_vld_d;
  logic        rd2_vld_q, rd2_vld_d;
  logic [31:0] rd1_data_q;
  logic [31:0] rd2_data_q, rd2_data_d;

  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_comb begin
    // A fresh request (idle or just granted) sees the full delay this cycle.
    cnt_eff = wait_q ? cnt_q : DELAY;
    gnt_o   = rst_n & req_i & (cnt_eff == 3'd0) & ~gnt_prev_q;
    wr_acc  = gnt_o & we_i;
    rd_acc  = gnt_o & ~we_i;

    cnt_d  = 3'd0;
    wait_d = 1'b0;
    if (req_i && !gnt_o) begin
      wait_d = 1'b1;
      cnt_d  = (cnt_eff != 3'd0) ? cnt_eff - 3'd1 : 3'd0;
    end

    gnt_prev_d = gnt_o;
    wr_rsp_d   = wr_acc;
    rd1_vld_d  = rd_acc;
    rd2_vld_d  = rd1_vld_q;
    rd2_data_d = rd1_vld_q ? rd1_data_q : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      wait_q     <= 1'b0;
      gnt_prev_q <= 1'b0;
      wr_rsp_q   <= 1'b0;
      rd1_vld_q  <= 1'b0;
      rd2_vld_q  <= 1'b0;
      rd2_data_q <= 32'h0;
    end else begin
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      gnt_prev_q <= gnt_prev_d;
      wr_rsp_q   <= wr_rsp_d;
      rd1_vld_q  <= rd1_vld_d;
      rd2_vld_q  <= rd2_vld_d;
      rd2_data_q <= rd2_data_d;
    end
  end

  // RAM port: byte-lane writes and a registered full-word read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (rd_acc) rd1_data_q <= mem_q[idx];
  end

  // Grant spacing guarantees write (N+1) and read (N+2) responses never overlap.
  assign rvalid_o = wr_rsp_q | rd2_vld_q;
  assign rdata_o  = rd2_vld_q ? rd2_data_q : 32'h0;

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Directed plus randomized bench for obi_data_mem_responder, checked against
// a word-array memory model and cycle-exact response timing.
module tb_obi_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        req3, we3, gnt3, rvalid3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  obi_data_mem_responder #(.MEM_WORDS(1024), .GNT_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .be_i(be0), .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0)
  );

  obi_data_mem_responder #(.MEM_WORDS(16), .GNT_DELAY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3),
    .be_i(be3), .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the zero-delay instance, responses checked cycle by cycle.
  task automatic txn0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input string tag);
    int waits;
    int idx;
    logic [31:0] exp;
    idx   = int'(addr[11:2]);
    req0  = 1'b1; we0 = we; addr0 = addr; be0 = be; wdata0 = wd;
    waits = 0;
    @(negedge clk);
    while (!gnt0 && waits < 20) begin
      tick();
      waits++;
      @(negedge clk);
    end
    chk({tag, "_gnt"}, 32'(gnt0), 32'd1);
    chk({tag, "_gnt_lat"}, 32'(waits), 32'd0);
    exp = we ? 32'h0 : ref_mem[idx];
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      end
    end
    tick();
    req0 = 1'b0; we0 = $urandom_range(0, 1); addr0 = $urandom; be0 = 4'($urandom); wdata0 = $urandom;
    @(negedge clk);
    chk({tag, "_rv1"}, 32'(rvalid0), 32'(we));
    chk({tag, "_rd1"}, rdata0, 32'h0);
    tick();
    @(negedge clk);
    chk({tag, "_rv2"}, 32'(rvalid0), 32'(!we));
    chk({tag, "_rd2"}, rdata0, exp);
    tick();
    $display("txn %s we=%0d addr=%h be=%b wdata=%h expect=%h", tag, we, addr, be, wd, exp);
  endtask

  initial begin
    logic [31:0] addrs [4];
    int grants;
    logic exp_rv;
    logic [31:0] exp_rd;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h1000; addrs[3] = 32'h44;

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; be0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h0; be3 = 4'hF; wdata3 = 32'hFFFF_FFFF;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    req0 = 1'b0; req3 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    txn0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, "wr10");
    txn0(1'b0, 32'h10, 4'hF, 32'h0, "rd10");
    txn0(1'b1, 32'h20, 4'hF, 32'h1122_3344, "wr20");
    txn0(1'b1, 32'h20, 4'b0100, 32'h00AA_0000, "wr20_lane2");
    txn0(1'b0, 32'h22, 4'hF, 32'h0, "rd22");
    chk("merge_model", ref_mem[8], 32'h11AA_3344);
    txn0(1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, "wr1000");
    txn0(1'b0, 32'h0, 4'hF, 32'h0, "rd0_wrap");
    txn0(1'b1, 32'h10, 4'h0, 32'h1234_5678, "wr10_be0");
    txn0(1'b0, 32'h10, 4'hF, 32'h0, "rd10_be0");

    // Four reads with req held high: grants every other cycle, responses two later.
    grants = 0;
    for (int c = 0; c < 11; c++) begin
      req0 = (grants < 4); we0 = 1'b0; be0 = 4'hF;
      addr0 = addrs[grants < 4 ? grants : 3];
      @(negedge clk);
      chk($sformatf("b2b_gnt_c%0d", c), 32'(gnt0), 32'((c % 2 == 0) && (c < 8)));
      if (gnt0) grants++;
      exp_rv = (c >= 2) && (c <= 8) && (c % 2 == 0);
      exp_rd = exp_rv ? ref_mem[int'(addrs[(c - 2) / 2][11:2])] : 32'h0;
      chk($sformatf("b2b_rv_c%0d", c), 32'(rvalid0), 32'(exp_rv));
      chk($sformatf("b2b_rd_c%0d", c), rdata0, exp_rd);
      tick();
    end
    $display("txn b2b reads grants=%0d", grants);

    // Delayed instance: steady request grants on cycle 3.
    for (int c = 0; c < 6; c++) begin
      req3 = (c <= 3); we3 = 1'b0; addr3 = 32'h8; be3 = 4'hF;
      @(negedge clk);
      chk($sformatf("d3a_gnt_c%0d", c), 32'(gnt3), 32'(c == 3));
      chk($sformatf("d3a_rv_c%0d", c), 32'(rvalid3), 32'(c == 5));
      tick();
    end
    $display("txn d3 steady request");
    // Request dropped at cycle 1 and re-raised at 2 restarts the delay: grant at 5.
    for (int c = 0; c < 8; c++) begin
      req3 = (c == 0) || (c >= 2 && c <= 5); we3 = 1'b1; addr3 = 32'hC; wdata3 = 32'h55AA_55AA;
      @(negedge clk);
      chk($sformatf("d3b_gnt_c%0d", c), 32'(gnt3), 32'(c == 5));
      chk($sformatf("d3b_rv_c%0d", c), 32'(rvalid3), 32'(c == 6));
      chk($sformatf("d3b_rd_c%0d", c), rdata3, 32'h0);
      tick();
    end
    req3 = 1'b0;
    $display("txn d3 interrupted request");

    // Reset right after a read is accepted: its response must never appear.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; be0 = 4'hF;
    @(negedge clk);
    chk("rstmid_gnt", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0; rst_n = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_rv_n%0d", c), 32'(rvalid0), 32'd0);
      chk($sformatf("rstmid_rd_n%0d", c), rdata0, 32'h0);
      tick();
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset mid-read");
    txn0(1'b0, 32'h10, 4'hF, 32'h0, "rd10_after_rst");
    txn0(1'b0, 32'h20, 4'hF, 32'h0, "rd20_after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      txn0(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
